// File: rtl/cve2_pkg.sv
// cve2_pkg
// Shared types and constants for the cve2 memory-side responder slice.
//   obi_resp_t        : one response record {rdata, err} carried by the delay line
//   ObiMaxRespLatency : largest response latency (grant to rvalid) a responder supports
package cve2_pkg;

  localparam int unsigned ObiMaxRespLatency = 8;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

endpackage

// File: rtl/cve2_resp_delay_line.sv
// cve2_resp_delay_line
// Fixed-depth shift register of {valid, data} records with no backpressure.
// A record entering at stage 0 appears on the outputs Depth cycles later.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   in_valid_i     : a record enters stage 0 at the next edge
//   in_data_i      : record payload (Width bits)
//   out_valid_o    : valid bit of the last stage
//   out_data_o     : payload of the last stage (all zero when out_valid_o=0)
module cve2_resp_delay_line #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  // Payload is zeroed on entry whenever the slot is empty, so every stage
  // (and hence the output) carries zeros alongside a cleared valid bit.
  // The payload is also cleared on reset to keep the outputs defined.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      data_q[0]  <= in_valid_i ? in_data_i : '0;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_data_o  = data_q[Depth-1];

endmodule

// File: rtl/cve2_obi_mem_responder.sv
// cve2_obi_mem_responder
// Memory-side responder for the cve2 req/gnt/rvalid protocol: a single-ported
// word SRAM with byte-enable writes, a fixed response latency and a bounded
// number of outstanding transactions. Out-of-range accesses answer with err=1.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   req_i / gnt_o     : request valid / request accepted this cycle
//   we_i, be_i        : write enable, byte enables
//   addr_i, wdata_i   : byte address (bits [1:0] ignored), write data
//   rvalid_o          : response valid (registered)
//   rdata_o, err_o    : read data (0 for writes/errors), error flag
//   stall_i           : grant inhibit for benches and integration
//   outstanding_o     : granted-but-not-responded count
module cve2_obi_mem_responder
  import cve2_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned IdxW     = $clog2(MemWords);
  localparam logic [29:0] BaseWord = BaseAddr[31:2];

  logic [31:0]     mem [MemWords];
  logic [29:0]     word_off;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic            retire;
  logic [3:0]      cnt_q;
  obi_resp_t       resp_in;
  obi_resp_t       resp_out;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^addr_i[1:0];

  // Working in word units makes the byte-offset compare against MemWords*4
  // equivalent; an address below BaseAddr wraps to a huge offset and fails.
  assign word_off = addr_i[31:2] - BaseWord;
  assign in_range = word_off < 30'(MemWords);
  assign idx      = word_off[IdxW-1:0];

  assign retire = rvalid_o;

  // A retiring response frees its slot in the same cycle, so a full responder
  // can still grant while rvalid_o is high.
  assign gnt_o = req_i & ~stall_i & ((cnt_q < 4'(MaxOutstanding)) | retire);

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read data is taken from the array before the edge, so it reflects the
  // contents ahead of any write committed at the same edge.
  always_comb begin
    resp_in.rdata = (in_range && !we_i) ? mem[idx] : 32'h0;
    resp_in.err   = ~in_range;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_q + 4'(gnt_o) - 4'(retire);
    end
  end

  cve2_resp_delay_line #(
    .Width ($bits(obi_resp_t)),
    .Depth (RespLatency)
  ) u_delay_line (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (gnt_o),
    .in_data_i   (resp_in),
    .out_valid_o (rvalid_o),
    .out_data_o  (resp_out)
  );

  assign rdata_o       = resp_out.rdata;
  assign err_o         = resp_out.err;
  assign outstanding_o = cnt_q;

  a_cnt_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= 4'(MaxOutstanding));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire |-> (cnt_q != 4'h0));

  a_gnt_needs_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    gnt_o |-> req_i);

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// tb_cve2_obi_mem_responder
// Scoreboard bench: a monitor predicts grant, outstanding count and response
// timing from a queue of in-flight requests plus a word-array memory model,
// and compares every cycle. Directed sequences add fixed expected values.
module tb_cve2_obi_mem_responder;

  localparam int unsigned MEMW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXO = 2;

  logic        clk_i;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        stall_i;
  logic [3:0]  outstanding_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [MEMW];

  cve2_obi_mem_responder #(
    .MemWords       (MEMW),
    .BaseAddr       (BASE),
    .RespLatency    (LAT),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .we_i          (we_i),
    .be_i          (be_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .stall_i       (stall_i),
    .outstanding_o (outstanding_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic bit modelInRange(input logic [31:0] a);
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, BASE};
    if (ua < ub) return 1'b0;
    return (ua - ub) < longint'(MEMW) * 4;
  endfunction

  function automatic int modelIndex(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Monitor: compares the DUT against the in-flight queue each cycle and
  // enqueues the predicted response whenever a grant is expected.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb.delete();
      checkOutput("reset_rvalid", 32'(rvalid_o), 32'd0);
      checkOutput("reset_rdata", rdata_o, 32'd0);
      checkOutput("reset_err", 32'(err_o), 32'd0);
      checkOutput("reset_outstanding", 32'(outstanding_o), 32'd0);
    end else begin
      bit   retire_exp;
      bit   gnt_exp;
      int   inflight;
      exp_t e;
      inflight   = sb.size();
      retire_exp = (inflight > 0) && (sb[0].due <= cyc);
      checkOutput("outstanding", 32'(outstanding_o), 32'(inflight));
      checkOutput("rvalid", 32'(rvalid_o), 32'(retire_exp));
      if (retire_exp) begin
        e = sb.pop_front();
        checkOutput("resp_rdata", rdata_o, e.data);
        checkOutput("resp_err", 32'(err_o), 32'(e.err));
      end else begin
        checkOutput("idle_rdata", rdata_o, 32'd0);
        checkOutput("idle_err", 32'(err_o), 32'd0);
      end
      gnt_exp = req_i && !stall_i && ((inflight < int'(MAXO)) || retire_exp);
      checkOutput("gnt", 32'(gnt_o), 32'(gnt_exp));
      if (gnt_exp) begin
        e.due = cyc + int'(LAT);
        if (!modelInRange(addr_i)) begin
          e.data = 32'h0;
          e.err  = 1'b1;
        end else begin
          int i;
          i      = modelIndex(addr_i);
          e.err  = 1'b0;
          e.data = we_i ? 32'h0 : mem_m[i];
          if (we_i) begin
            for (int b = 0; b < 4; b++) begin
              if (be_i[b]) mem_m[i][8*b +: 8] = wdata_i[8*b +: 8];
            end
          end
        end
        sb.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Issues one request and holds it until granted; returns at posedge+1
  // after the grant edge with req_i dropped.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data);
    bit got = 1'b0;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    be_i    = be;
    wdata_i = data;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (gnt_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) failNow("grant_timeout");
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
  endtask

  task automatic expectResp(input string name, input logic [31:0] data, input logic err);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) failNow({name, "_rvalid"});
    else begin
      checkOutput({name, "_rdata"}, rdata_o, data);
      checkOutput({name, "_err"}, 32'(err_o), 32'(err));
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int exp_g[5] = '{1, 1, 0, 1, 1};
    int exp_o[5] = '{0, 1, 2, 2, 2};
    int ng;
    rst_ni  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    be_i    = 4'h0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    stall_i = 1'b0;
    idle(3);
    rst_ni = 1'b1;
    idle(2);

    $display("[TB] preload words 0..63");
    for (int w = 0; w < 64; w++) applyStimulus(1'b1, 32'(w * 4), 4'hF, $urandom);
    idle(6);

    $display("[TB] write then read");
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; be_i = 4'hF; wdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    checkOutput("t1_gnt_same_cycle", 32'(gnt_o), 32'd1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    expectResp("t1_write", 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h10, 4'hF, 32'h0);
    expectResp("t1_read", 32'hDEADBEEF, 1'b0);
    idle(4);

    $display("[TB] partial write");
    applyStimulus(1'b1, 32'h20, 4'hF, 32'h11223344);
    idle(5);
    applyStimulus(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    idle(5);
    applyStimulus(1'b0, 32'h20, 4'hF, 32'h0);
    expectResp("t2_partial", 32'h11BB33DD, 1'b0);
    idle(4);

    $display("[TB] out-of-range");
    applyStimulus(1'b1, 32'h0, 4'hF, 32'hC0FFEE00);
    applyStimulus(1'b1, 32'hFFC, 4'hF, 32'h12345678);
    idle(6);
    applyStimulus(1'b0, 32'h1000, 4'hF, 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 4'hF, 32'hFFFFFFFF);
    expectResp("t3_oor_read", 32'h0, 1'b1);
    expectResp("t3_oor_write", 32'h0, 1'b1);
    idle(4);
    applyStimulus(1'b0, 32'h0, 4'hF, 32'h0);
    expectResp("t3_word0", 32'hC0FFEE00, 1'b0);
    applyStimulus(1'b0, 32'hFFC, 4'hF, 32'h0);
    expectResp("t3_word1023", 32'h12345678, 1'b0);
    idle(4);

    $display("[TB] outstanding limit");
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("t4_gnt_c%0d", i), 32'(gnt_o), 32'(exp_g[i]));
      checkOutput($sformatf("t4_outst_c%0d", i), 32'(outstanding_o), 32'(exp_o[i]));
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    idle(8);

    $display("[TB] stall and drain");
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    ng = 0;
    for (int i = 0; i < 20 && ng < 2; i++) begin
      @(negedge clk_i);
      if (gnt_o) ng++;
      @(posedge clk_i); #1;
      if (ng == 1) addr_i = 32'h20;
    end
    if (ng < 2) failNow("t5_two_grants");
    stall_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("t5_stall_gnt", 32'(gnt_o), 32'd0);
    end
    @(posedge clk_i); #1;
    stall_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t5_resume_gnt", 32'(gnt_o), 32'd1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    idle(8);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'h40, 4'hF, 32'h5A5A5A5A);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    repeat (6) begin
      @(negedge clk_i);
      checkOutput("t6_no_rvalid", 32'(rvalid_o), 32'd0);
      checkOutput("t6_outstanding", 32'(outstanding_o), 32'd0);
    end
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 32'h40, 4'hF, 32'h0);
    expectResp("t6_persist", 32'h5A5A5A5A, 1'b0);
    idle(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      int r;
      r       = int'($urandom_range(0, 9));
      req_i   = ($urandom_range(0, 3) != 0);
      we_i    = $urandom_range(0, 1) == 1;
      be_i    = 4'($urandom);
      wdata_i = $urandom;
      stall_i = ($urandom_range(0, 9) == 0);
      if (r == 0) addr_i = 32'h1000 + 32'($urandom_range(0, 4000));
      else if (r == 1) addr_i = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else addr_i = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
      @(posedge clk_i); #1;
    end
    req_i   = 1'b0;
    stall_i = 1'b0;
    idle(10);
    checkOutput("final_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cve2_obi_mem_responder.md
Name: cve2_obi_mem_responder

Overview:
- Memory-side responder for the cve2 core's instruction and data request/grant/rvalid protocol.
- Single-ported, word-organised SRAM model with byte-enable writes, a programmable fixed response latency and a bounded number of outstanding transactions.
- Out-of-range accesses return an error response.
- Used in simulation benches and small FPGA/ASIC subsystems as the target of the core's instr_* or data_* ports.

Parameters:
- MemWords, 1024, number of 32-bit words; must be a power of two, at least 4.
- BaseAddr, 32'h0000_0000, byte address of word 0; must be aligned to MemWords*4.
- RespLatency, 1, cycles from grant to rvalid; range 1..8.
- MaxOutstanding, 2, maximum granted-but-not-responded requests; range 1..RespLatency+1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request valid from core
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- addr_i  in  32  byte address; bits [1:0] ignored
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  response error flag
- stall_i  in  1  bench/integration grant inhibit
- outstanding_o  out  4  current outstanding count

Behaviour:
- Reset state: rst_ni is asynchronous and active-low; clk_i is the clock.
  - Reset clears the delay line and the outstanding counter.
  - Outputs after reset: rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0; gnt_o=0 while req_i=0.
  - Memory contents are not reset.
- Grant (combinational): gnt_o = req_i & ~stall_i & (cnt < MaxOutstanding | retire), where retire = rvalid_o this cycle.
  - Grant never depends on we_i, addr_i or be_i.
- Accepting a request (on gnt_o=1):
  - Range check: in_range = (addr_i - BaseAddr) < MemWords*4, computed in 32 bits unsigned; wrap-around below BaseAddr is out of range.
  - Index = (addr_i - BaseAddr)[log2(MemWords)+1:2].
  - Write, in range: for each b with be_i[b]=1, mem[idx][8b+7:8b] <= wdata_i[8b+7:8b] at the grant clock edge.
  - Write, be_i=4'b0000: legal, no byte changes, normal response.
  - Read, in range: data is sampled from mem[idx] at grant time, before any write in the same edge. Only one request can be granted per cycle, so this is only an ordering rule.
  - Out of range: no memory effect; response carries err=1, rdata=0.
  - A response record {rdata, err} enters stage 0 of the delay line.
- Delay line: RespLatency stages of {valid, rdata, err}, shifted every cycle with no backpressure (the core always accepts rvalid).
  - rvalid_o, rdata_o and err_o are registered outputs of the last stage.
  - With RespLatency=1, a grant at edge N gives rvalid_o=1 in cycle N+1.
- Responses return strictly in grant order.
  - Back-to-back grants give back-to-back rvalid.
  - When rvalid_o=0, rdata_o and err_o are forced to 0.
- Outstanding counter: cnt_next = cnt + gnt - retire.
  - Simultaneous grant and retire leaves the count unchanged.
  - The count never exceeds MaxOutstanding and never underflows. Assert this.
- stall_i=1 forces gnt_o=0. In-flight responses still drain.
- Reset mid-operation drops in-flight responses. Writes already granted persist in memory.
- Assertion: gnt_o only when req_i.

Decomposition:
- cve2_pkg gains obi_resp_t (typedef struct packed {logic [31:0] rdata; logic err;}) and constant ObiMaxRespLatency = 8.
- Sub-module cve2_resp_delay_line: parameterised shift register of {valid, obi_resp_t}, with width and depth parameters and async reset of the valid bits.
- The top holds the SRAM array, range check, counter and grant logic.

Test Plan:
1. Write then read, RespLatency=1.
   - Stimulus: write 0x0000_0010 be=1111 data 0xDEADBEEF; then read 0x10.
   - Required: gnt same cycle as req; rvalid 1 cycle later; rdata=0xDEADBEEF, err=0.
2. Partial write.
   - Stimulus: word at 0x20 holds 0x11223344; write be=0101 data 0xAABBCCDD; then read 0x20.
   - Required: rdata=0x11BB33DD.
3. Out-of-range access, MemWords=1024, BaseAddr=0.
   - Stimulus: read 0x1000; then write 0xFFFF_FFFC.
   - Required: both responses err=1, rdata=0; a subsequent read of 0x0 shows memory unchanged.
4. Outstanding limit, RespLatency=3, MaxOutstanding=2.
   - Stimulus: continuous req.
   - Required: gnt at cycles 0 and 1, gnt=0 at cycle 2, gnt=1 at cycle 3 (same cycle as first rvalid); outstanding_o sequence 0,1,2,2,2.
5. Stall and drain.
   - Stimulus: two reads granted, then stall_i=1 for 5 cycles with req held.
   - Required: both rvalids still arrive in order; no gnt during stall; gnt resumes in the first cycle after stall_i falls.
6. Reset mid-operation, RespLatency=4.
   - Stimulus: write 0x40 data 0x5A5A5A5A, then assert rst_ni low 2 cycles after grant.
   - Required: no rvalid after reset, outstanding_o=0; a subsequent read of 0x40 returns 0x5A5A5A5A.
